// File: rtl/scancode_tracker.sv
`default_nettype none
// ============================================================================
// Module      : scancode_tracker
// Description : Turns the raw PS/2 byte stream into a held-key stack and
//               presents the most recently pressed key that is still down.
//               Optional stuck-key timeout: define SCANCODE_TRACKER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module scancode_tracker #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_en,
  output logic [7:0] held_code,
  output logic       held_valid,
  output logic [3:0] held_count,
  output logic       key_event
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_stack     [DEPTH];
  logic [7:0] w_stack_nxt [DEPTH];
  logic [3:0] r_count, w_count_nxt;
  logic       r_key_event;
  logic       w_make, w_brk, w_clear, w_timeout;
  logic       w_hit;
  logic [3:0] w_hit_idx;
  logic [7:0] w_code_nxt;

  // Parameter ranges outside the supported envelope leave this marker block.
  if (DEPTH < 2 || DEPTH > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_out_of_range
  end

`ifdef SCANCODE_TRACKER_TIMEOUT_EN
  logic [31:0] r_timer;

  assign w_timeout = !ps2_byte_en && held_valid &&
                     (r_timer == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      r_timer <= '0;
    else if (ps2_byte_en || !held_valid || w_timeout)
      r_timer <= '0;
    else
      r_timer <= r_timer + 32'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Protocol decode: prefix tracking and classification of the current byte.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_clear     = 1'b0;
    if (ps2_byte_en) begin
      case (r_state)
        S_IDLE: begin
          case (ps2_byte)
            8'hF0: w_state_nxt = S_BRK;
            8'hE0: w_state_nxt = S_EXT;
            8'hAA: w_clear = 1'b1;
            8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            default: w_make = 1'b1;
          endcase
        end
        S_BRK: begin
          w_state_nxt = S_IDLE;
          w_brk       = (ps2_byte != 8'hF0) && (ps2_byte != 8'hE0);
        end
        S_EXT:     w_state_nxt = (ps2_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_clear     = 1'b1;
    end
  end

  // Stack update; entries at or above r_count are kept at zero.
  always_comb begin
    w_stack_nxt = r_stack;
    w_count_nxt = r_count;
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_hit && (4'(i) < r_count) && (r_stack[i] == ps2_byte)) begin
        w_hit     = 1'b1;
        w_hit_idx = 4'(i);
      end
    end
    if (w_clear) begin
      for (int i = 0; i < DEPTH; i++) w_stack_nxt[i] = 8'h00;
      w_count_nxt = '0;
    end else if (w_make && !w_hit) begin
      if (r_count < 4'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++)
          if (4'(i) == r_count) w_stack_nxt[i] = ps2_byte;
        w_count_nxt = r_count + 4'd1;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) w_stack_nxt[i] = r_stack[i+1];
        w_stack_nxt[DEPTH-1] = ps2_byte;
      end
    end else if (w_brk && w_hit) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (4'(i) >= w_hit_idx) w_stack_nxt[i] = r_stack[i+1];
      w_stack_nxt[DEPTH-1] = 8'h00;
      w_count_nxt = r_count - 4'd1;
    end
  end

  always_comb begin
    held_code  = 8'h00;
    w_code_nxt = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (4'(i) + 4'd1 == r_count)     held_code  = r_stack[i];
      if (4'(i) + 4'd1 == w_count_nxt) w_code_nxt = w_stack_nxt[i];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_key_event <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_key_event <= (w_code_nxt != held_code);
      r_stack     <= w_stack_nxt;
    end
  end

  assign held_valid = (r_count != 4'd0);
  assign held_count = r_count;
  assign key_event  = r_key_event;

endmodule
`default_nettype wire

// File: tb/tb_scancode_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_scancode_tracker
// Description : Directed self-checking bench for scancode_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scancode_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_byte;
  logic       ps2_byte_en;
  logic [7:0] held_code;
  logic       held_valid;
  logic [3:0] held_count;
  logic       key_event;

  int n_checks = 0;
  int n_errors = 0;
  int ev_cnt   = 0;

  always #10 clk = ~clk;

  scancode_tracker #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .ps2_byte    (ps2_byte),
    .ps2_byte_en (ps2_byte_en),
    .held_code   (held_code),
    .held_valid  (held_valid),
    .held_count  (held_count),
    .key_event   (key_event)
  );

  task automatic chk(input string tag, input logic [7:0] code, input logic valid,
                     input logic [3:0] count, input logic ev);
    logic [13:0] obs, exp;
    obs = {held_code, held_valid, held_count, key_event};
    exp = {code, valid, count, ev};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed code=%h valid=%b count=%0d ev=%b, expected code=%h valid=%b count=%0d ev=%b",
             tag, obs[13:6], obs[5], obs[4:1], obs[0], code, valid, count, ev);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One strobe; returns at the following negedge, half a cycle after the update.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_byte    = b;
    ps2_byte_en = 1'b1;
    @(negedge clk);
    ps2_byte_en = 1'b0;
    if (key_event) ev_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    ps2_byte    = 8'h00;
    ps2_byte_en = 1'b0;
    idle(3);
    chk("reset_state", 8'h00, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    idle(2);

    // Basic press / release
    send(8'h15); chk("press_15", 8'h15, 1'b1, 4'd1, 1'b1);
    idle(1);     chk("event_one_cycle", 8'h15, 1'b1, 4'd1, 1'b0);
    send(8'hF0); chk("f0_no_change", 8'h15, 1'b1, 4'd1, 1'b0);
    send(8'h15); chk("release_15", 8'h00, 1'b0, 4'd0, 1'b1);

    // Overlapping keys
    ev_cnt = 0;
    send(8'h15); chk("ovl_make_15", 8'h15, 1'b1, 4'd1, 1'b1);
    send(8'h1D); chk("ovl_make_1d", 8'h1D, 1'b1, 4'd2, 1'b1);
    send(8'hF0);
    send(8'h1D); chk("ovl_break_1d", 8'h15, 1'b1, 4'd1, 1'b1);
    send(8'hF0);
    send(8'h15); chk("ovl_break_15", 8'h00, 1'b0, 4'd0, 1'b1);
    chk_int("ovl_event_count", ev_cnt, 4);

    // Typematic repeat and stray break
    ev_cnt = 0;
    send(8'h24); chk("rep_first", 8'h24, 1'b1, 4'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(8'h24); chk("rep_again", 8'h24, 1'b1, 4'd1, 1'b0);
    end
    send(8'hF0);
    send(8'h2D); chk("stray_break", 8'h24, 1'b1, 4'd1, 1'b0);
    chk_int("rep_event_count", ev_cnt, 1);
    send(8'hF0);
    send(8'h24); chk("rep_release", 8'h00, 1'b0, 4'd0, 1'b1);

    // Overflow: 0x15 is evicted by the fifth make
    send(8'h15); send(8'h1D); send(8'h24);
    send(8'h2D); chk("ovf_full", 8'h2D, 1'b1, 4'd4, 1'b1);
    send(8'h2C); chk("ovf_push", 8'h2C, 1'b1, 4'd4, 1'b1);
    send(8'hF0); send(8'h2C); chk("ovf_brk_2c", 8'h2D, 1'b1, 4'd3, 1'b1);
    send(8'hF0); send(8'h2D); chk("ovf_brk_2d", 8'h24, 1'b1, 4'd2, 1'b1);
    send(8'hF0); send(8'h24); chk("ovf_brk_24", 8'h1D, 1'b1, 4'd1, 1'b1);
    send(8'hF0); send(8'h1D); chk("ovf_brk_1d", 8'h00, 1'b0, 4'd0, 1'b1);
    send(8'hF0); send(8'h15); chk("ovf_15_gone", 8'h00, 1'b0, 4'd0, 1'b0);

    // Middle-entry break keeps order of the entries above it
    send(8'h15); send(8'h1D); send(8'h24);
    send(8'hF0); send(8'h1D); chk("mid_break", 8'h24, 1'b1, 4'd2, 1'b0);
    send(8'hF0); send(8'h24); chk("mid_compact", 8'h15, 1'b1, 4'd1, 1'b1);
    send(8'hAA);

    // Back-to-back strobes
    @(negedge clk); ps2_byte = 8'h15; ps2_byte_en = 1'b1;
    @(negedge clk); ps2_byte = 8'h1D;
    @(negedge clk); ps2_byte_en = 1'b0;
    chk("b2b_two_makes", 8'h1D, 1'b1, 4'd2, 1'b1);

    // Extended and control bytes
    send(8'hE0); send(8'h75); chk("ext_make", 8'h1D, 1'b1, 4'd2, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h75); chk("ext_break", 8'h1D, 1'b1, 4'd2, 1'b0);
    send(8'hFA); chk("ack_ignored", 8'h1D, 1'b1, 4'd2, 1'b0);
    send(8'hF0); send(8'hF0); send(8'h1D); chk("proto_err", 8'h1D, 1'b1, 4'd2, 1'b0);
    send(8'hAA); chk("bat_clear", 8'h00, 1'b0, 4'd0, 1'b1);

    // Reset between F0 and the code byte
    send(8'h15);
    send(8'hF0);
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    @(negedge clk); chk("mid_reset", 8'h00, 1'b0, 4'd0, 1'b0);
    send(8'h1D); chk("after_reset_make", 8'h1D, 1'b1, 4'd1, 1'b1);
    send(8'hAA);

`ifdef SCANCODE_TRACKER_TIMEOUT_EN
    send(8'h15);
    idle(99);  chk("to_before", 8'h15, 1'b1, 4'd1, 1'b0);
    idle(1);   chk("to_clear", 8'h00, 1'b0, 4'd0, 1'b1);
    send(8'h15);
    for (int i = 0; i < 4; i++) begin
      idle(48);
      send(8'h15);
    end
    idle(60);  chk("to_kept_alive", 8'h15, 1'b1, 4'd1, 1'b0);
`else
    send(8'h15);
    idle(200); chk("no_timeout", 8'h15, 1'b1, 4'd1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
